// File: rtl/lock_code_programmer.sv
// Code-enrollment FSM: authenticate with the stored code, enter a new code, confirm it.
// Repeated failures trigger a buzzer lockout; all outputs come from registered state.
module lock_code_programmer #(
    parameter logic [7:0]  DEFAULT_CODE   = 8'b00110011,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       program_en,
    input  logic [2:1] bn,
    output logic [7:0] code_out,
    output logic [1:0] counter,
    output logic [3:0] state,
    output logic       busy,
    output logic       LED_right,
    output logic       LED_wrong,
    output logic       Buzzer
);
    localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_AUTH    = 4'd1,
        S_NEW     = 4'd2,
        S_CONFIRM = 4'd3,
        S_DONE    = 4'd4,
        S_FAIL    = 4'd5,
        S_LOCKOUT = 4'd6
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic [7:0]      new_q, new_d;
    logic [5:0]      shift_q, shift_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [2:0]      fails_q, fails_d;
    logic [LW-1:0]   lock_q, lock_d;
    logic [7:0]      value;

    // Complete phase value including the digit on the current edge.
    assign value = {shift_q, bn};

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            code_q  <= DEFAULT_CODE;
            new_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            fails_q <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            new_q   <= new_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            fails_q <= fails_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        new_d   = new_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fails_d = fails_q;
        lock_d  = lock_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (program_en) state_d = S_AUTH;
            end
            S_AUTH, S_NEW, S_CONFIRM: begin
                if (!program_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    shift_d = value[5:0];
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        case (state_q)
                            S_AUTH:  state_d = (value == code_q) ? S_NEW : S_FAIL;
                            S_NEW: begin
                                new_d   = value;
                                state_d = S_CONFIRM;
                            end
                            default: begin
                                if (value == new_q) begin
                                    state_d = S_DONE;
                                    code_d  = new_q;
                                end else begin
                                    state_d = S_FAIL;
                                end
                            end
                        endcase
                    end
                end
            end
            S_DONE: begin
                fails_d = '0;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                if (fails_q + 3'd1 == 3'(MAX_FAILS)) begin
                    fails_d = '0;
                    lock_d  = '0;
                    state_d = S_LOCKOUT;
                end else begin
                    fails_d = fails_q + 3'd1;
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (lock_q == LW'(LOCKOUT_CYCLES - 1)) state_d = S_IDLE;
                else lock_d = lock_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign code_out  = code_q;
    assign counter   = cnt_q;
    assign state     = state_q;
    assign busy      = (state_q != S_IDLE);
    assign LED_right = (state_q == S_DONE);
    assign LED_wrong = (state_q == S_FAIL);
    assign Buzzer    = (state_q == S_LOCKOUT);
endmodule

// File: tb/tb_lock_code_programmer.sv
// Self-checking bench for lock_code_programmer: table of attempts, random attempts
// against a transaction-level model, and a clear-during-confirm sequence.
module tb_lock_code_programmer;
    localparam int          L    = 16;
    localparam int          MAXF = 3;
    localparam logic [7:0]  DEF  = 8'b00110011;
    localparam int OC_COMMIT = 0, OC_FAILA = 1, OC_FAILC = 2, OC_ABORT = 3;

    logic       clock = 1'b0;
    logic       clear, program_en;
    logic [2:1] bn;
    logic [7:0] code_out;
    logic [1:0] counter;
    logic [3:0] state;
    logic       busy, LED_right, LED_wrong, Buzzer;

    lock_code_programmer #(
        .DEFAULT_CODE(DEF), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(L)
    ) dut (
        .clock(clock), .clear(clear), .program_en(program_en), .bn(bn),
        .code_out(code_out), .counter(counter), .state(state), .busy(busy),
        .LED_right(LED_right), .LED_wrong(LED_wrong), .Buzzer(Buzzer)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [7:0] m_code;
    int         m_fails;

    typedef struct {
        logic [7:0] a, n, c;
        int         ab;
        logic [7:0] exp_code;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] digit(input logic [7:0] a, input logic [7:0] n,
                                         input logic [7:0] c, input int k);
        logic [7:0] w;
        w = (k < 4) ? a : (k < 8) ? n : c;
        return 2'(w >> (6 - 2 * (k % 4)));
    endfunction

    // Attempt outcome from current stored code and fail count.
    task automatic predict(input logic [7:0] a, input logic [7:0] n, input logic [7:0] c,
                           input int ab, output int oc, output bit lk);
        if (ab >= 0 && ab < 4)       oc = OC_ABORT;
        else if (a != m_code)        oc = OC_FAILA;
        else if (ab >= 0 && ab < 12) oc = OC_ABORT;
        else if (c != n)             oc = OC_FAILC;
        else                         oc = OC_COMMIT;
        lk = (oc == OC_FAILA || oc == OC_FAILC) && (m_fails + 1 == MAXF);
    endtask

    function automatic int exp_state(input int t, input int oc, input int ab, input bit lk);
        int ce;
        ce = (oc == OC_ABORT) ? ab + 1 : (oc == OC_FAILA) ? 4 : 12;
        if (t >= 1 && t <= ce) return 1 + (t - 1) / 4;
        if (t == ce + 1) return (oc == OC_COMMIT) ? 4 : (oc == OC_ABORT) ? 0 : 5;
        if (lk && t >= ce + 2 && t < ce + 2 + L) return 6;
        return 0;
    endfunction

    task automatic run_attempt(input logic [7:0] a, input logic [7:0] n,
                               input logic [7:0] c, input int ab);
        int oc, es, es1, ce;
        bit lk;
        logic [17:0] act, exp;
        predict(a, n, c, ab, oc, lk);
        ce = (oc == OC_ABORT) ? ab + 1 : (oc == OC_FAILA) ? 4 : 12;
        for (int t = 0; t < 32; t++) begin
            es = exp_state(t, oc, ab, lk);
            if (t == 0)                  program_en = 1'b1;
            else if (es >= 1 && es <= 3) program_en = !(oc == OC_ABORT && t == ab + 1);
            else if (es == 6)            program_en = 1'($urandom);
            else                         program_en = 1'b0;
            bn = (t >= 1 && t <= 12) ? digit(a, n, c, t - 1) : 2'($urandom);
            step();
            es1 = exp_state(t + 1, oc, ab, lk);
            exp = {4'(es1),
                   (es1 >= 1 && es1 <= 3) ? 2'(t % 4) : 2'd0,
                   es1 != 0, es1 == 4, es1 == 5, es1 == 6,
                   (oc == OC_COMMIT && t + 1 >= ce + 1) ? n : m_code};
            act = {state, counter, busy, LED_right, LED_wrong, Buzzer, code_out};
            check($sformatf("cycle%0d_oc%0d", t + 1, oc), 32'(act), 32'(exp));
        end
        if (oc == OC_COMMIT) begin
            m_code  = n;
            m_fails = 0;
        end else if (oc != OC_ABORT) begin
            m_fails = lk ? 0 : m_fails + 1;
        end
    endtask

    initial begin
        logic [17:0] rst_vec;
        logic [7:0]  ra, rn, rc;
        int          rab;

        tbl[0] = '{8'h31, 8'h00, 8'h00, -1, 8'h33};
        tbl[1] = '{8'h33, 8'h55, 8'h54, -1, 8'h33};
        tbl[2] = '{8'h33, 8'h00, 8'h00,  6, 8'h33};
        tbl[3] = '{8'h33, 8'h93, 8'h93, -1, 8'h93};
        tbl[4] = '{8'h93, 8'h93, 8'h93, -1, 8'h93};
        tbl[5] = '{8'h00, 8'h11, 8'h11, -1, 8'h93};
        tbl[6] = '{8'h00, 8'h11, 8'h11, -1, 8'h93};
        tbl[7] = '{8'h00, 8'h11, 8'h11, -1, 8'h93};
        tbl[8] = '{8'h93, 8'h33, 8'h33, -1, 8'h33};

        clear = 1'b1; program_en = 1'b0; bn = 2'd0;
        step();
        program_en = 1'b1; bn = 2'd3;
        step();
        rst_vec = {state, counter, busy, LED_right, LED_wrong, Buzzer, code_out};
        check("reset", 32'(rst_vec), 32'({10'd0, DEF}));
        clear = 1'b0; program_en = 1'b0;
        m_code = DEF; m_fails = 0;

        for (int i = 0; i < 9; i++) begin
            run_attempt(tbl[i].a, tbl[i].n, tbl[i].c, tbl[i].ab);
            check($sformatf("tbl%0d_code", i), 32'(code_out), 32'(tbl[i].exp_code));
        end

        for (int i = 0; i < 30; i++) begin
            rn  = 8'($urandom);
            ra  = ($urandom_range(0, 3) != 0) ? m_code : 8'($urandom);
            rc  = ($urandom_range(0, 4) >= 2) ? rn : 8'($urandom);
            rab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : -1;
            run_attempt(ra, rn, rc, rab);
        end

        // Commit a non-default code, then clear midway through confirmation.
        run_attempt(m_code, 8'hC6, 8'hC6, -1);
        check("commit_c6", 32'(code_out), 32'h0000_00C6);
        program_en = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            bn = digit(8'hC6, 8'h12, 8'h12, k);
            step();
        end
        check("pre_clear_state", 32'(state), 32'd3);
        clear = 1'b1;
        step();
        rst_vec = {state, counter, busy, LED_right, LED_wrong, Buzzer, code_out};
        check("clear_in_confirm", 32'(rst_vec), 32'({10'd0, DEF}));
        clear = 1'b0; program_en = 1'b0;
        m_code = DEF; m_fails = 0;
        run_attempt(8'h00, 8'h00, 8'h00, -1);
        run_attempt(8'h00, 8'h00, 8'h00, -1);
        run_attempt(DEF, 8'h93, 8'h93, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lock_code_programmer.md
# lock_code_programmer

Code-enrollment front end for the digital locker. It lets a user replace the locker's 8-bit unlock code through the same 2-bit button digit interface the door FSM uses. The user authenticates with the current code, enters a new code, then repeats it to confirm. It drives the stored code (`code_out`) that the door FSM compares against, in place of the static switch code, and enforces a buzzer lockout after repeated failures.

## Interface
- `DEFAULT_CODE`, 8'b00110011: value of `code_out` after reset.
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout (1..7).
- `LOCKOUT_CYCLES`, 16: length of lockout in clock cycles (>=1, counter width sized from it).
- `clock`, in, 1: sole clock; all state changes on rising edge.
- `clear`, in, 1: reset, synchronous, active-high.
- `program_en`, in, 1: level request to enter or stay in programming mode.
- `bn`, in, [2:1]: one code digit sampled per clock while capturing; any value 0..3 is a valid digit.
- `code_out`, out, [7:0]: currently stored unlock code, registered.
- `counter`, out, [1:0]: digits captured so far in the current 4-digit phase.
- `state`, out, [3:0]: current FSM state encoding.
- `busy`, out, 1: high in every state except IDLE.
- `LED_right`, out, 1: one-cycle pulse when a new code is committed.
- `LED_wrong`, out, 1: one-cycle pulse on authentication or confirmation failure.
- `Buzzer`, out, 1: high for the whole lockout period.

## Operation
- State encodings: IDLE=0, AUTH=1, NEW=2, CONFIRM=3, DONE=4, FAIL=5, LOCKOUT=6. Unused encodings go to IDLE on the next edge.
- Digit order is MSB first. The first digit of a phase fills bits [7:6] and the fourth fills [1:0].
- IDLE: if `program_en`=1, go to AUTH with `counter`=0.
- AUTH, NEW and CONFIRM are capture states. Each edge shifts `bn` into that phase's register and increments `counter`. On the 4th digit (`counter`=3), `counter` wraps to 0 and the phase resolves using the complete 8-bit value including the current `bn`:
  - AUTH: if the value equals `code_out`, go to NEW; otherwise go to FAIL.
  - NEW: the value is held as `new_code`; go to CONFIRM unconditionally.
  - CONFIRM: if the value equals `new_code`, go to DONE and load `code_out` from `new_code` on that same edge; otherwise go to FAIL.
- DONE (1 cycle): `LED_right`=1, fail count cleared, then go to IDLE.
- FAIL (1 cycle): `LED_wrong`=1 and the fail count increments.
  - If the incremented count equals `MAX_FAILS`, go to LOCKOUT and clear the fail count.
  - Otherwise go to IDLE.
- LOCKOUT: `Buzzer`=1 for exactly `LOCKOUT_CYCLES` cycles, then go to IDLE. `program_en` and `bn` are ignored.
- Abort: `program_en`=0 in AUTH, NEW or CONFIRM returns to IDLE on the next edge.
  - That edge captures no digit, `counter` resets to 0, and `code_out` is unchanged.
  - The fail count is not incremented.
  - Abort takes priority over digit capture.
- `program_en` has no effect in DONE, FAIL or LOCKOUT.
- Setting the new code equal to the old code is legal and commits normally.
- The fail count persists across aborts and successful authentications. Only DONE, entering LOCKOUT, or `clear` resets it.

## Timing
- Reset (`clear`=1 at an edge) gives `state`=IDLE, `code_out`=`DEFAULT_CODE`, `counter`=0, fail count 0, and `busy`, `LED_right`, `LED_wrong`, `Buzzer` all 0.
- `clear` overrides every other input, including mid-capture and mid-lockout.
- All outputs are registered or decoded from the registered state. There are no combinational paths from input to output.
- Successful sequence, with `program_en` sampled high at edge 0:
  - AUTH during cycles 1-4, NEW during 5-8, CONFIRM during 9-12.
  - DONE at cycle 13: `code_out` is new and `LED_right`=1.
  - IDLE at cycle 14.
  - Latency from enable to commit is 13 cycles.
- Auth failure: FAIL at cycle 5 with `LED_wrong`=1, IDLE at cycle 6.
- Confirm failure: FAIL at cycle 13.
- Lockout: entered the cycle after the FAIL that reaches `MAX_FAILS`. `Buzzer` is high for `LOCKOUT_CYCLES` cycles, then IDLE.
- Back-to-back requests: from IDLE with `program_en` still 1, AUTH begins on the next edge.

## Test plan
- Reset, then `program_en`=1 and digits 0,3,0,3 / 2,1,0,3 / 2,1,0,3 -> AUTH passes; `code_out`=8'b10010011 and `LED_right` pulse at cycle 13; `state` returns to 0.
- Auth with 0,3,0,1 against 8'b00110011 -> `LED_wrong` pulse at cycle 5; `code_out` unchanged; `counter` back to 0.
- New 1,1,1,1 then confirm 1,1,1,0 -> FAIL at cycle 13; `code_out` remains 8'b00110011.
- Three consecutive wrong auths -> third FAIL leads to `Buzzer`=1 for exactly 16 cycles while `bn`/`program_en` toggle is ignored; then IDLE with fail count 0.
- Drop `program_en` after 2 NEW digits -> IDLE next edge; no `LED_wrong`; fail count unchanged; a retry starts again at AUTH.
- Assert `clear` in the CONFIRM phase after a prior successful commit -> `code_out`=8'b00110011 and all outputs 0 on the next edge.
